// File: rtl/spi_arbiter.sv
// Shares one SPI master between two requesters: 1-deep request buffer per port,
// round-robin launch, completion/read-data routing and a watchdog abort.
module spi_arbiter #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int GAP_CYC     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt0,
    input  logic [2:0]  ss0,
    input  logic [15:0] data0,
    output logic        done0,
    input  logic        wrt1,
    input  logic [2:0]  ss1,
    input  logic [15:0] data1,
    output logic        done1,
    output logic        busy0,
    output logic        busy1,
    output logic        err,
    output logic        ovr,
    output logic [7:0]  rd_data,
    output logic        wrt_SPI,
    output logic [2:0]  ss,
    output logic [15:0] SPI_data,
    input  logic        SPI_done,
    input  logic [7:0]  EEP_data,
    output logic [1:0]  state_dbg
);

    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    localparam int GW = $clog2(GAP_CYC) + 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0] GAP_LAST     = GW'(GAP_CYC - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, GAP} state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic [GW-1:0]   gap_cnt;
    logic            owner;
    logic            rr_ptr;
    logic            pend0;
    logic            pend1;
    logic [2:0]      ss_buf0;
    logic [2:0]      ss_buf1;
    logic [15:0]     data_buf0;
    logic [15:0]     data_buf1;
    logic            pick;

    // Handshake: wrt_i is a one-cycle request taken whenever busy_i is low;
    // a wrt_i while busy_i is high is dropped and sets ovr; done_i retires it.
    assign busy0     = pend0;
    assign busy1     = pend1;
    assign state_dbg = state;

    // On a tie the port that was not served last wins.
    assign pick = (pend0 && pend1) ? ~rr_ptr : pend1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            gap_cnt   <= '0;
            owner     <= 1'b0;
            rr_ptr    <= 1'b0;
            pend0     <= 1'b0;
            pend1     <= 1'b0;
            ss_buf0   <= '0;
            ss_buf1   <= '0;
            data_buf0 <= '0;
            data_buf1 <= '0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err       <= 1'b0;
            ovr       <= 1'b0;
            rd_data   <= '0;
            wrt_SPI   <= 1'b0;
            ss        <= '0;
            SPI_data  <= '0;
        end else begin
            wrt_SPI <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            err     <= 1'b0;

            if (wrt0) begin
                if (pend0) begin
                    ovr <= 1'b1;
                end else begin
                    pend0     <= 1'b1;
                    ss_buf0   <= ss0;
                    data_buf0 <= data0;
                end
            end
            if (wrt1) begin
                if (pend1) begin
                    ovr <= 1'b1;
                end else begin
                    pend1     <= 1'b1;
                    ss_buf1   <= ss1;
                    data_buf1 <= data1;
                end
            end

            case (state)
                IDLE: begin
                    if (pend0 || pend1) begin
                        owner    <= pick;
                        ss       <= pick ? ss_buf1 : ss_buf0;
                        SPI_data <= pick ? data_buf1 : data_buf0;
                        wrt_SPI  <= 1'b1;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    timer <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    // A completion on the last watchdog cycle still wins over the abort.
                    if (SPI_done || timer == TIMEOUT_LAST) begin
                        rd_data <= SPI_done ? EEP_data : 8'hEE;
                        err     <= !SPI_done;
                        if (owner) begin
                            done1 <= 1'b1;
                            pend1 <= 1'b0;
                        end else begin
                            done0 <= 1'b1;
                            pend0 <= 1'b0;
                        end
                        rr_ptr  <= owner;
                        gap_cnt <= '0;
                        state   <= GAP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: directed scenarios plus random traffic, checked every
// cycle against a timestamp-based transaction model and a launch scoreboard.
module tb_spi_arbiter;

    localparam int TIMEOUT_CYC = 4096;
    localparam int GAP_CYC     = 2;

    logic        clk;
    logic        rst_n;
    logic        wrt0, wrt1;
    logic [2:0]  ss0, ss1;
    logic [15:0] data0, data1;
    logic        done0, done1, busy0, busy1, err, ovr;
    logic [7:0]  rd_data;
    logic        wrt_SPI;
    logic [2:0]  ss;
    logic [15:0] SPI_data;
    logic        SPI_done;
    logic [7:0]  EEP_data;
    logic [1:0]  state_dbg;

    spi_arbiter #(.TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .wrt0(wrt0), .ss0(ss0), .data0(data0), .done0(done0),
        .wrt1(wrt1), .ss1(ss1), .data1(data1), .done1(done1),
        .busy0(busy0), .busy1(busy1), .err(err), .ovr(ovr), .rd_data(rd_data),
        .wrt_SPI(wrt_SPI), .ss(ss), .SPI_data(SPI_data),
        .SPI_done(SPI_done), .EEP_data(EEP_data), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    int t = 0;
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, t);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_pend[2];
    logic [2:0]  m_ss[2];
    logic [15:0] m_data[2];
    bit          m_ovr;
    bit          m_fly;
    int          m_last, m_owner, m_launch, m_idle_from;
    bit [1:0]    e_done;
    bit          e_err, e_wrt;
    logic [2:0]  e_ss;
    logic [15:0] e_spi_data;
    logic [7:0]  e_rd;
    logic [18:0] exp_q[$];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 0;
            m_ss[i]   = '0;
            m_data[i] = '0;
        end
        m_ovr = 0; m_fly = 0; m_last = 0; m_owner = 0; m_launch = 0; m_idle_from = 0;
        e_done = '0; e_err = 0; e_wrt = 0; e_ss = '0; e_spi_data = '0; e_rd = '0;
        exp_q.delete();
    endtask

    // Predicts the registered outputs of the next cycle from this cycle's inputs.
    task automatic model_step();
        bit op[2];
        bit wr[2];
        op[0] = m_pend[0]; op[1] = m_pend[1];
        wr[0] = wrt0;      wr[1] = wrt1;
        e_done = '0; e_err = 0; e_wrt = 0;
        if (!m_fly && t >= m_idle_from && (op[0] || op[1])) begin
            m_owner    = (op[0] && op[1]) ? 1 - m_last : (op[1] ? 1 : 0);
            e_ss       = m_ss[m_owner];
            e_spi_data = m_data[m_owner];
            e_wrt      = 1;
            m_fly      = 1;
            m_launch   = t + 1;
            exp_q.push_back({e_ss, e_spi_data});
        end else if (m_fly && t > m_launch && (SPI_done === 1'b1 || t == m_launch + TIMEOUT_CYC)) begin
            e_rd             = (SPI_done === 1'b1) ? EEP_data : 8'hEE;
            e_err            = (SPI_done !== 1'b1);
            e_done[m_owner]  = 1;
            m_pend[m_owner]  = 0;
            m_last           = m_owner;
            m_fly            = 0;
            m_idle_from      = t + 1 + GAP_CYC;
        end
        for (int i = 0; i < 2; i++) begin
            if (wr[i]) begin
                if (op[i]) begin
                    m_ovr = 1;
                end else begin
                    m_pend[i] = 1;
                    m_ss[i]   = (i == 0) ? ss0 : ss1;
                    m_data[i] = (i == 0) ? data0 : data1;
                end
            end
        end
    endtask

    // ---------------- driver / monitor ----------------
    int          spi_lat = 0;
    bit          eep_fixed = 0;
    logic [7:0]  eep_val = '0;
    bit          noise_en = 0;
    bit          rand_lat = 0;
    int          timeouts_left = 0;
    int          launch_cnt = 0;
    int          done_cnt[2];
    int          last_done_cyc[2];
    int          last_launch_cyc = 0;
    bit          last_err = 0;
    int          done_q[$];
    int          obs_cyc[$];
    logic [15:0] obs_data[$];

    task automatic step();
        EEP_data = eep_fixed ? eep_val : 8'($urandom);
        if (m_fly && spi_lat > 0 && t == m_launch + spi_lat) SPI_done = 1'b1;
        if (noise_en && $urandom_range(0, 99) == 0) SPI_done = 1'b1;
        model_step();
        @(posedge clk);
        t++;
        @(negedge clk);
        check("pulses", 32'({done0, done1, err, wrt_SPI}), 32'({e_done[0], e_done[1], e_err, e_wrt}));
        check("spi_out", 32'({ss, SPI_data}), 32'({e_ss, e_spi_data}));
        check("rd_data", 32'(rd_data), 32'(e_rd));
        check("status", 32'({busy0, busy1, ovr}), 32'({m_pend[0], m_pend[1], m_ovr}));
        if (wrt_SPI) begin
            launch_cnt++;
            obs_cyc.push_back(t);
            obs_data.push_back(SPI_data);
            last_launch_cyc = t;
            if (exp_q.size() == 0) check("launch_extra", 32'(exp_q.size()), 32'd1);
            else check("launch_sb", 32'({ss, SPI_data}), 32'(exp_q.pop_front()));
        end
        if (done0) begin done_cnt[0]++; done_q.push_back(0); last_done_cyc[0] = t; last_err = err; end
        if (done1) begin done_cnt[1]++; done_q.push_back(1); last_done_cyc[1] = t; last_err = err; end
        if (rand_lat && e_wrt) begin
            if (timeouts_left > 0 && $urandom_range(0, 39) == 0) begin
                spi_lat = 0;
                timeouts_left--;
            end else begin
                spi_lat = $urandom_range(1, 40);
            end
        end
        wrt0 = 1'b0; wrt1 = 1'b0; SPI_done = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check("reset_ctl", 32'({done0, done1, err, ovr, busy0, busy1, wrt_SPI, state_dbg}), 32'd0);
        check("reset_dat", 32'({ss, SPI_data, rd_data}), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int n0, d0, d1, t0, start_n, re0, re1;
        rst_n = 1'b0; wrt0 = 0; wrt1 = 0; ss0 = '0; ss1 = '0; data0 = '0; data1 = '0;
        SPI_done = 0; EEP_data = '0;
        done_cnt[0] = 0; done_cnt[1] = 0; last_done_cyc[0] = 0; last_done_cyc[1] = 0;
        @(negedge clk);
        do_reset();

        // single read
        t0 = t; eep_fixed = 1; eep_val = 8'h5C; spi_lat = 20;
        wrt0 = 1; ss0 = 3'b100; data0 = 16'h0A00;
        step();
        run(30);
        check("single_launch_lat", 32'(obs_cyc[0] - t0), 32'd2);
        check("single_spi_out", 32'({ss, SPI_data}), 32'({3'd4, 16'h0A00}));
        check("single_done_lat", 32'(last_done_cyc[0] - obs_cyc[0]), 32'd21);
        check("single_rd", 32'(rd_data), 32'h5C);
        check("single_counts", 32'({done_cnt[0][7:0], done_cnt[1][7:0]}), 32'h0100);
        eep_fixed = 0;

        // simultaneous requests
        n0 = launch_cnt; spi_lat = 5;
        wrt0 = 1; ss0 = 3'd1; data0 = 16'h1302;
        wrt1 = 1; ss1 = 3'd4; data1 = 16'h0100;
        step();
        run(40);
        check("sim_launches", 32'(launch_cnt - n0), 32'd2);
        if (launch_cnt - n0 >= 2) begin
            check("sim_first", 32'(obs_data[n0]), 32'h0100);
            check("sim_second", 32'(obs_data[n0 + 1]), 32'h1302);
            check("sim_gap", 32'(obs_cyc[n0 + 1] - last_done_cyc[1]), 32'(GAP_CYC + 1));
        end

        // fairness: re-request on each done while the other port is pending
        start_n = done_q.size(); re0 = 0; re1 = 0; spi_lat = 6;
        wrt0 = 1; data0 = 16'($urandom); ss0 = 3'($urandom);
        wrt1 = 1; data1 = 16'($urandom); ss1 = 3'($urandom);
        step();
        for (int k = 0; k < 600 && (done_q.size() - start_n) < 8; k++) begin
            if (e_done[0] && re0 < 3) begin wrt0 = 1; data0 = 16'($urandom); ss0 = 3'($urandom); re0++; end
            if (e_done[1] && re1 < 3) begin wrt1 = 1; data1 = 16'($urandom); ss1 = 3'($urandom); re1++; end
            step();
        end
        check("fair_count", 32'(done_q.size() - start_n), 32'd8);
        if (done_q.size() > start_n) check("fair_first", 32'(done_q[start_n]), 32'd1);
        for (int i = start_n + 1; i < done_q.size(); i++)
            check("fair_alt", 32'(done_q[i]), 32'(1 - done_q[i - 1]));
        run(5);

        // overrun
        n0 = launch_cnt; spi_lat = 10;
        wrt1 = 1; ss1 = 3'd2; data1 = 16'h3C5A;
        step();
        run(2);
        wrt1 = 1; ss1 = 3'd3; data1 = 16'hBEEF;
        step();
        run(30);
        check("ovr_set", 32'(ovr), 32'd1);
        check("ovr_launches", 32'(launch_cnt - n0), 32'd1);
        if (launch_cnt > n0) check("ovr_data", 32'(obs_data[n0]), 32'h3C5A);

        // timeout, then a late SPI_done during GAP
        d0 = done_cnt[0]; spi_lat = 0;
        wrt0 = 1; ss0 = 3'd4; data0 = 16'h0B11;
        step();
        for (int k = 0; k < 5000 && done_cnt[0] == d0; k++) step();
        check("to_wait", 32'(done_cnt[0] - d0), 32'd1);
        check("to_lat", 32'(last_done_cyc[0] - last_launch_cyc), 32'(TIMEOUT_CYC + 1));
        check("to_err", 32'(last_err), 32'd1);
        check("to_rd", 32'(rd_data), 32'hEE);
        SPI_done = 1;
        step();
        run(10);
        check("to_late", 32'(done_cnt[0] - d0), 32'd1);

        // asynchronous reset while BUSY
        d0 = done_cnt[0]; d1 = done_cnt[1]; spi_lat = 0;
        wrt0 = 1; ss0 = 3'd0; data0 = 16'h7777;
        step();
        run(10);
        do_reset();
        run(20);
        check("rst_idle", 32'({busy0, busy1}), 32'd0);
        check("rst_nodone", 32'(done_cnt[0] + done_cnt[1]), 32'(d0 + d1));

        // random traffic
        noise_en = 1; rand_lat = 1; timeouts_left = 2;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0) begin wrt0 = 1; ss0 = 3'($urandom); data0 = 16'($urandom); end
            if ($urandom_range(0, 7) == 0) begin wrt1 = 1; ss1 = 3'($urandom); data1 = 16'($urandom); end
            step();
        end
        noise_en = 0;
        run(20);
        check("launch_left", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
